// File: rtl/elastic_skid_buffer_pkg.sv
// elastic_skid_buffer_pkg: width helpers and stream monitor parameters shared by the buffer.
package elastic_skid_buffer_pkg;
    localparam int STREAM_MON_MAX_STALL = 1024;
    localparam int STREAM_MON_CHECK_STABLE = 1;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/elastic_skid_buffer_ram.sv
// elastic_skid_buffer_ram: DEPTH x DATA_WIDTH storage, one write port, one async read port.
module elastic_skid_buffer_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer: DEPTH-entry elastic stream buffer with registered ready/valid/data,
// occupancy level and synchronous flush.
module elastic_skid_buffer
    import elastic_skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LEVEL_W = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LEVEL_W-1:0]    level
);
    localparam int AW = ptr_width(DEPTH);

    logic [AW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
    logic [LEVEL_W-1:0]    r_level, w_level_kept, w_level_next;
    logic                  r_in_ready, r_out_valid, w_push, w_pop;
    logic [DATA_WIDTH-1:0] r_out_data, w_ram_rdata, w_out_data_next;

    assign w_push        = in_valid & r_in_ready;
    assign w_pop         = r_out_valid & out_ready;
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    assign w_level_kept  = r_level - LEVEL_W'(w_pop);
    assign w_level_next  = w_level_kept + LEVEL_W'(w_push);
    // Every word is also written to storage; the head copy in out_data bypasses the RAM
    // only when nothing older survives this cycle.
    assign w_out_data_next = (w_level_kept != '0) ? w_ram_rdata : (w_push ? in_data : r_out_data);

    elastic_skid_buffer_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH),
        .AW(AW)
    ) u_ram (
        .clk(clk),
        .i_we(w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(in_data),
        .i_raddr(w_rd_ptr_next),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + AW'(w_push);
            r_rd_ptr    <= w_rd_ptr_next;
            r_level     <= w_level_next;
            r_in_ready  <= w_level_next < LEVEL_W'(DEPTH);
            r_out_valid <= w_level_next != '0;
            r_out_data  <= w_out_data_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_level;
endmodule

// File: tb/tb_elastic_skid_buffer.sv
// tb_elastic_skid_buffer: queue-model checked bench with directed scenarios and a random soak.
module tb_elastic_skid_buffer;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    logic          m_rdy = 1'b0;
    logic          m_push, m_pop;

    always #5 clk = ~clk;

    elastic_skid_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level(level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is a FIFO queue; ready is "queue not full" as of the previous edge.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
        if (rst) begin
            q.delete();
            m_rdy = 1'b0;
        end else begin
            m_push = in_valid && m_rdy;
            m_pop  = (q.size() != 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_push) q.push_back(in_data);
            m_rdy = q.size() < DEPTH;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(m_rdy));
            check("level", 32'(level), 32'(q.size()));
            if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_level", 32'(level), 0);
        check("rst_out_data", 32'(out_data), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);

        // stream-through
        got.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            @(negedge clk);
            check("stream_data", 32'(out_data), i);
            check("stream_level_le1", 32'(level <= 1), 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", 32'(got[i]), i + 1);

        // fill and stall
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'hA0 + DW'(i);
            @(negedge clk);
        end
        check("full_level", 32'(level), 4);
        check("full_in_ready", 32'(in_ready), 0);
        in_data = 8'hA4;
        repeat (3) begin
            @(negedge clk);
            check("stall_level", 32'(level), 4);
            check("stall_data", 32'(out_data), 32'hA0);
        end

        // full release and drain
        out_ready = 1'b1;
        @(negedge clk);
        check("release_level", 32'(level), 3);
        check("release_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("drain_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("drain_order", 32'(got[i]), 32'hA0 + i);

        // flush with concurrent pop and push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'hB0 + DW'(i);
            @(negedge clk);
        end
        check("pre_flush_level", 32'(level), 3);
        got.delete();
        flush = 1'b1;
        in_data = 8'hB3;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        check("flush_delivered", got.size(), 1);
        if (got.size() != 0) check("flush_word", 32'(got[0]), 32'hB0);
        @(negedge clk);
        check("flush_dropped", 32'(level), 0);

        // random soak with occasional flush and one mid-run reset
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0 || c < 2000 ? $urandom_range(0, 1) : 1);
            flush     = ($urandom_range(0, 99) == 0);
            rst       = (c == 5000);
            @(negedge clk);
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
